// File: rtl/palette_arbiter_if.sv
// Palette arbiter bus: render lookup, CPU $3F00-$3FFF access and palette RAM port.
// The arbiter uses the slave modport; the environment drives the master modport.
interface palette_arbiter_if;
    logic       render_valid;
    logic [4:0] render_idx;
    logic       mask_grey;
    logic       pix_valid;
    logic [5:0] pix_color;
    logic       pix_stale;

    logic       cpu_req;
    logic       cpu_wr;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;

    logic [4:0] pal_addr;
    logic       pal_wr;
    logic [7:0] pal_wdata;
    logic [7:0] pal_rdata;

    modport slave (
        input  render_valid, render_idx, mask_grey,
        output pix_valid, pix_color, pix_stale,
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output pal_addr, pal_wr, pal_wdata,
        input  pal_rdata
    );

    modport master (
        output render_valid, render_idx, mask_grey,
        input  pix_valid, pix_color, pix_stale,
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  pal_addr, pal_wr, pal_wdata,
        output pal_rdata
    );
endinterface

// File: rtl/palette_arbiter.sv
// Shares the single-port PPU palette RAM between per-dot render lookups (priority)
// and CPU $2007 accesses, with a bounded CPU wait before a forced grant.
module palette_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input logic               clk,
    input logic               rst,
    palette_arbiter_if.slave  bus
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       ack_wr_q;
    logic       lookup_q;
    logic       pix_valid_q;
    logic       pix_stale_q;
    logic       grey_q;
    logic [5:0] color_q;

    logic       cpu_grant;
    logic       render_grant;
    logic [4:0] render_addr;
    logic [7:0] rdata_colour;
    logic [5:0] lookup_color;
    logic       cpu_ack;

    // Transparent pixels (pixel bits 00) all resolve to the universal backdrop entry.
    assign render_addr = (bus.render_idx[1:0] == 2'b00) ? 5'h00 : bus.render_idx;

    always_comb begin
        cpu_grant = 1'b0;
        if (state_q == StIdle) begin
            cpu_grant = bus.cpu_req && (!bus.render_valid || wait_q == MaxWait);
        end
        render_grant = bus.render_valid && !cpu_grant;

        state_d = (state_q == StIdle && cpu_grant) ? StAck : StIdle;

        if (!bus.cpu_req || cpu_grant) begin
            wait_d = 8'h00;
        end else if (state_q == StIdle && wait_q != MaxWait) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        bus.pal_addr  = bus.cpu_addr;
        bus.pal_wr    = 1'b0;
        bus.pal_wdata = bus.cpu_wdata;
        if (cpu_grant) begin
            bus.pal_wr = bus.cpu_wr;
        end else if (render_grant) begin
            bus.pal_addr = render_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= 8'h00;
            ack_wr_q    <= 1'b0;
            lookup_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_stale_q <= 1'b0;
            grey_q      <= 1'b0;
            color_q     <= 6'h00;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            lookup_q    <= render_grant;
            pix_valid_q <= bus.render_valid;
            pix_stale_q <= bus.render_valid && cpu_grant;
            grey_q      <= bus.mask_grey;
            if (cpu_grant) begin
                ack_wr_q <= bus.cpu_wr;
            end
            // Hold the last looked-up colour for stale and idle dots.
            if (lookup_q) begin
                color_q <= lookup_color;
            end
        end
    end

    always_comb begin
        rdata_colour  = bus.pal_rdata & 8'h3F;
        lookup_color  = rdata_colour[5:0] & (grey_q ? 6'h30 : 6'h3F);
        cpu_ack       = (state_q == StAck) && !rst;
        bus.cpu_ack   = cpu_ack;
        bus.cpu_rdata = (cpu_ack && !ack_wr_q) ? rdata_colour : 8'h00;
        bus.pix_valid = pix_valid_q;
        bus.pix_stale = pix_stale_q;
        bus.pix_color = lookup_q ? lookup_color : color_q;
    end

endmodule

// File: doc/palette_arbiter.md
Name: palette_arbiter

Overview:
- Shares the single-port 32x8 PPU palette RAM between two requesters: the pixel pipeline's per-dot colour lookup and the CPU's $2007 accesses to $3F00-$3FFF.
- Rendering has priority. A wait counter bounds CPU starvation.
- Applies transparent-to-backdrop address forcing and PPUMASK greyscale masking on the render path.
- Sits between the PPU register/VRAM-address logic, the pixel mux and the palette RAM (1-cycle registered read, mirroring done inside the RAM).

Parameters:
- MAX_WAIT, 8, cycles cpu_req may be denied before the CPU is force-granted over rendering (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- render_valid  in  1  pixel lookup request this cycle
- render_idx  in  5  {sprite/bg select, palette[1:0], pixel[1:0]}
- mask_grey  in  1  PPUMASK greyscale bit
- pix_valid  out  1  pix_color valid
- pix_color  out  6  NES master-palette colour index
- pix_stale  out  1  pixel was not looked up (CPU forced grant); colour held from previous pixel
- cpu_req  in  1  CPU palette access request
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  5  palette address (v[4:0])
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, {2'b00, colour}, valid while cpu_ack
- pal_addr  out  5  RAM address (combinational mux)
- pal_wr  out  1  RAM write enable (combinational)
- pal_wdata  out  8  RAM write data (= cpu_wdata)
- pal_rdata  in  8  RAM registered read data (1-cycle latency)

Behaviour:
- Reset values: pix_valid=0, pix_stale=0, pix_color=0, cpu_ack=0, cpu_rdata=0, wait counter=0, state=IDLE. Reset mid-transaction drops any pending CPU access with no ack. The requester re-issues after reset.
- States:
  - IDLE: arbitrate.
  - ACK: the cycle after a CPU grant. cpu_ack=1. cpu_req is ignored in this cycle, so CPU throughput is at most 1 access per 2 cycles. Return to IDLE.
- Arbitration (IDLE, each cycle):
  - CPU grant when cpu_req && (!render_valid || wait_cnt==MAX_WAIT).
  - Otherwise render grant when render_valid.
  - Otherwise idle: pal_addr=cpu_addr, pal_wr=0.
- In ACK, render requests are still served normally. The RAM port is free because CPU data is captured from pal_rdata.
- Render grant:
  - pal_addr = (render_idx[1:0]==0) ? 5'h00 : render_idx. pal_wr=0.
  - Next cycle: pix_valid=1, pix_stale=0, pix_color = pal_rdata[5:0] & (grey_q ? 6'h30 : 6'h3F).
  - grey_q is mask_grey registered at the grant edge.
- Render denied (render_valid && CPU force-grant):
  - Next cycle: pix_valid=1, pix_stale=1, pix_color = previous pix_color (greyscale not reapplied).
- No render request: next cycle pix_valid=0, pix_color holds.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each IDLE cycle with cpu_req=1 and no CPU grant.
  - Clears on CPU grant or when cpu_req=0.
- CPU grant: pal_addr=cpu_addr, pal_wr=cpu_wr, pal_wdata=cpu_wdata.
- ACK cycle: cpu_ack=1.
  - Read: cpu_rdata = {2'b00, pal_rdata[5:0]}.
  - Write: cpu_rdata = 0. A write ack means the RAM has been updated.
- CPU handshake: cpu_addr/cpu_wr/cpu_wdata must stay stable from request until ack.
- Read-after-write: a read granted after a write's ack returns the new data, including through the $3F10/$3F00 mirror pair.
- Render latency: request edge t → pixel valid in cycle after t (1 cycle), fully pipelined at one pixel per cycle.

Test Plan:
- Reset then CPU write cpu_addr=5'h01, wdata=8'h16, render idle → pal_wr=1 same cycle, cpu_ack next cycle. A subsequent read of 5'h01 → cpu_rdata=8'h16.
- RAM preloaded [0x00]=0x0F, [0x05]=0x2A. render_idx sequence 5'h05, 5'h04, 5'h1C on consecutive cycles → pix_color 0x2A, 0x0F, 0x0F (1C mirrors to 0C, forced to 00), pix_valid high 3 cycles, pix_stale=0.
- Greyscale: [0x05]=0x2A, mask_grey=1, render_idx=5'h05 → pix_color=0x20. Toggle mask_grey the next cycle → only later pixels are affected.
- Starvation, MAX_WAIT=8: render_valid held high, cpu_req asserted → no grant for 8 cycles, forced grant on the 9th. That pixel reports pix_stale=1 with the previous colour. cpu_ack follows, and rendering resumes with pix_stale=0.
- Write 8'h30 to 5'h10, then read 5'h00 → 8'h30. Read with cpu_req held high through ack → second ack arrives no sooner than 2 cycles after the first.
- Assert rst in the cycle after a CPU grant → no cpu_ack, all outputs zero next cycle, counter cleared.
